div_unit: RTL and testbench
===========================

# div_unit

Sequential signed 32-bit divider for the datapath's multi-cycle arithmetic group, the division counterpart of the Booth multiplier. On a start pulse it latches dividend and divisor and runs a 32-iteration restoring shift-subtract on operand magnitudes, then applies sign correction. It writes the quotient to Lo and the remainder to Hi (MIPS DIV semantics) and raises a done flag for the control unit. Divide-by-zero is detected up front and reported on a dedicated flag without iterating.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- div_ctrl  in  1  start; sampled each rising edge; high starts a new division.
- a  in  32  dividend, two's complement; sampled only on the start edge.
- b  in  32  divisor, two's complement; sampled only on the start edge.
- Hi  out  32  remainder register.
- Lo  out  32  quotient register.
- div_end  out  1  done flag, registered.
- div_zero  out  1  divide-by-zero flag, registered.

## Operation
- Reset values: Hi=0, Lo=0, div_end=0, div_zero=0, state IDLE, counter 0, internal registers 0.
- States: IDLE, RUN, FIX, DONE.
  - IDLE/DONE + div_ctrl=1, b≠0: latch |a|, |b|, sign(a), sign(a) XOR sign(b); clear div_end and div_zero; counter=32; go to RUN.
  - IDLE/DONE + div_ctrl=1, b=0: go to DONE; set div_zero=1 and div_end=1 on that same edge; Hi/Lo unchanged.
  - RUN: each edge shifts {rem[32:0], quo[31:0]} left by 1, bringing in the next dividend MSB. Trial = rem − |b| (33-bit). If the trial is non-negative, rem=trial and quo LSB=1; otherwise rem is kept and quo LSB=0. Decrement the counter; when it reaches 0, go to FIX.
  - FIX: Lo = quotient sign ? −quo : quo. Hi = sign(a) ? −rem[31:0] : rem[31:0]. Set div_end=1. Go to DONE.
  - DONE: hold Hi, Lo, div_end and div_zero until the next start or reset.
- Arithmetic:
  - Quotient truncates toward zero.
  - The remainder takes the dividend's sign, or is zero.
  - |0x80000000| is handled as unsigned 0x80000000.
  - 0x80000000 / −1 wraps: Lo=0x80000000, Hi=0, no flag.
- div_ctrl=1 in RUN or FIX aborts the current division and restarts with the new a/b, same as the IDLE case. Hi/Lo keep their previous values.
- div_ctrl held high re-triggers on every edge, so the control unit must pulse it for one cycle.
- Reset at any point, including mid-RUN, returns everything to reset values on that edge.

## Timing
- Start edge E0, b≠0:
  - RUN occupies iterations E1..E32.
  - FIX at E33: Hi, Lo and div_end=1 are visible after E33.
  - Latency is 33 cycles from the start edge to div_end.
- Start edge E0, b=0: div_zero=1 and div_end=1 after E0, so latency is 1 edge.
- div_end and div_zero deassert on the start edge of the next operation.
- a and b may change freely after E0 without affecting the result.
- Hi and Lo change only at FIX or reset, never mid-iteration.

## Test plan
- Reset, then a=100, b=7, pulse div_ctrl -> div_end rises exactly after the 33rd edge following start; Lo=14, Hi=2, div_zero=0.
- a=−7 (0xFFFFFFF9), b=2 -> Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1). Then a=7, b=−2 -> Lo=0xFFFFFFFD, Hi=1. Then a=−7, b=−2 -> Lo=3, Hi=0xFFFFFFFF.
- After a completed 100/7, start a=5, b=0 -> after the start edge div_zero=1 and div_end=1; Hi=2 and Lo=14 remain unchanged. A following start with a=9, b=3 clears div_zero and yields Lo=3, Hi=0.
- a=0x80000000, b=0xFFFFFFFF -> Lo=0x80000000, Hi=0. Then a=0x80000000, b=1 -> Lo=0x80000000, Hi=0. Then a=3, b=10 -> Lo=0, Hi=3.
- Abort and restart: start 100/7, re-pulse div_ctrl with a=50, b=5 at iteration 10 -> div_end rises 33 edges after the second start with Lo=10, Hi=0; no intermediate div_end.
- Reset mid-operation: start 1000/3 and assert reset at iteration 20 -> Hi=0, Lo=0, div_end=0 after that edge, and div_end stays 0 for 40 idle cycles.

Source files
------------

// File: rtl/div_if.sv
// Handshake and result bus between the control unit and the sequential divider.
interface div_if;
  logic        div_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        div_end;
  logic        div_zero;

  // Control unit side: issues operands and the start pulse, reads results.
  modport master (
    output div_ctrl, a, b,
    input  Hi, Lo, div_end, div_zero
  );

  // Divider side: consumes operands and the start pulse, drives results.
  modport slave (
    input  div_ctrl, a, b,
    output Hi, Lo, div_end, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Sequential signed 32-bit divider (MIPS DIV semantics).
// Restoring shift-subtract on operand magnitudes, then sign correction.
// Quotient goes to Lo, remainder to Hi; divide-by-zero is flagged up front.
module div_unit (
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  // The partial remainder is always below |b| <= 2^31, so its bit 32 is
  // permanently zero and is not stored; the trial subtraction stays 33-bit.
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        sign_a;
  logic        sign_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] trial;

  // Operand magnitudes and one restoring iteration step.
  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    abs_a   = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    abs_b   = bus.b[31] ? (32'd0 - bus.b) : bus.b;
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dvs};
  end

  // Control FSM, iteration datapath and registered result outputs.
  // NOTE: reset is synchronous (sampled on clk) and all state uses non-blocking
  // assignments so every register updates from the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      sign_a       <= 1'b0;
      sign_q       <= 1'b0;
      bus.Hi       <= '0;
      bus.Lo       <= '0;
      bus.div_end  <= 1'b0;
      bus.div_zero <= 1'b0;
    end else if (bus.div_ctrl) begin
      // A start is honoured in every state; an active division is abandoned.
      if (bus.b == 32'd0) begin
        state        <= DONE;
        bus.div_end  <= 1'b1;
        bus.div_zero <= 1'b1;
      end else begin
        state        <= RUN;
        cnt          <= 6'd32;
        rem          <= '0;
        quo          <= abs_a;
        dvs          <= abs_b;
        sign_a       <= bus.a[31];
        sign_q       <= bus.a[31] ^ bus.b[31];
        bus.div_end  <= 1'b0;
        bus.div_zero <= 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          // quo doubles as the dividend shifter: its MSB feeds the remainder
          // while quotient bits enter at the LSB.
          if (trial[32]) begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end else begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b1};
          end
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= FIX;
        end
        FIX: begin
          bus.Lo      <= sign_q ? (32'd0 - quo) : quo;
          bus.Hi      <= sign_a ? (32'd0 - rem) : rem;
          bus.div_end <= 1'b1;
          state       <= DONE;
        end
        default: ; // IDLE and DONE hold all results until the next start.
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands,
// scored against plain signed-arithmetic expectations held in a queue.
module tb_div_unit;

  typedef struct {
    logic        zero;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic clk;
  logic reset;
  div_if bus ();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic busy = 1'b0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got end=%b zero=%b Hi=%h Lo=%h, expected end=%b zero=%b Hi=%h Lo=%h",
               name, act[65], act[64], act[63:32], act[31:0],
               req[65], req[64], req[63:32], req[31:0]);
    end
  endtask

  // Reference: signed division truncating toward zero, remainder with the
  // dividend's sign, MIN / -1 wrapping to MIN with zero remainder.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sa, sb;
    sa = a;
    sb = b;
    e.zero = (b == 32'd0);
    e.q    = '0;
    e.r    = '0;
    if (!e.zero) begin
      if (sa == 32'sh8000_0000 && sb == -1) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = sa / sb;
        e.r = sa % sb;
      end
    end
    return e;
  endfunction

  // Drive a one-cycle start pulse; called at a falling edge, returns at the next one.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.div_ctrl = 1'b1;
    bus.a        = a;
    bus.b        = b;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.div_ctrl = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic wait_done(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      if (!busy && exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (i == max_cycles) begin
      n_errors++;
      $display("FAIL wait_done: result still pending after %0d cycles", max_cycles);
    end
  endtask

  // Monitor: tracks what the visible outputs must be on every cycle.
  initial begin : monitor
    logic        started, rst_seen;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_end, exp_zero;
    int          cnt;
    exp_t        cur;
    exp_hi = '0; exp_lo = '0; exp_end = 1'b0; exp_zero = 1'b0; cnt = 0;
    forever begin
      @(posedge clk);
      started  = bus.div_ctrl;
      rst_seen = reset;
      @(negedge clk);
      if (rst_seen) begin
        busy = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_end = 1'b0; exp_zero = 1'b0;
        check("reset_state", {bus.div_end, bus.div_zero, bus.Hi, bus.Lo},
              {exp_end, exp_zero, exp_hi, exp_lo});
      end else begin
        if (started) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: start seen with no expected entry");
          end else begin
            cur = exp_q.pop_front();
            if (cur.zero) begin
              busy = 1'b0;
              exp_end = 1'b1;
              exp_zero = 1'b1;
            end else begin
              busy = 1'b1;
              cnt = 33;
              exp_end = 1'b0;
              exp_zero = 1'b0;
            end
          end
        end else if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            exp_end = 1'b1;
            exp_lo = cur.q;
            exp_hi = cur.r;
          end
        end
        check(busy ? "running" : "result", {bus.div_end, bus.div_zero, bus.Hi, bus.Lo},
              {exp_end, exp_zero, exp_hi, exp_lo});
      end
    end
  end

  // Stimulus.
  initial begin : stim
    logic [31:0] ra, rb;
    reset        = 1'b1;
    bus.div_ctrl = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    start(32'd100, 32'd7);                       wait_done(60);
    start(32'hFFFF_FFF9, 32'd2);                 wait_done(60);
    start(32'd7, 32'hFFFF_FFFE);                 wait_done(60);
    start(32'hFFFF_FFF9, 32'hFFFF_FFFE);         wait_done(60);

    start(32'd100, 32'd7);                       wait_done(60);
    start(32'd5, 32'd0);                         wait_done(60);
    repeat (3) @(negedge clk);
    start(32'd9, 32'd3);                         wait_done(60);

    start(32'h8000_0000, 32'hFFFF_FFFF);         wait_done(60);
    start(32'h8000_0000, 32'd1);                 wait_done(60);
    start(32'd3, 32'd10);                        wait_done(60);

    // Abort at iteration 10 and restart.
    start(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    start(32'd50, 32'd5);                        wait_done(60);

    // Reset at iteration 20, then 40 idle cycles.
    start(32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Random operands with a mix of magnitudes, zero and extreme divisors.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'd0 - $urandom_range(1, 15);
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      start(ra, rb);
      wait_done(60);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
